// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data memory between the core and the
// loader port, with round-robin ties, locked bursts and a bounded lock hold.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic [CW-1:0] burst_cnt, burst_cnt_nxt;
    logic [AW-1:0] addr_hold;
    logic          idle_g0, idle_g1;
    logic          cont;

    // Tie goes to whichever port was not served last.
    assign idle_g0 = req0 & (~req1 | last_gnt);
    assign idle_g1 = req1 & ~idle_g0;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        cont = 1'b0;
        unique case (state)
            OWN0: begin
                if (req0) begin
                    if (burst_cnt == CNT_MAX && req1) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                        cont = 1'b1;
                    end
                end else begin
                    gnt0 = idle_g0;
                    gnt1 = idle_g1;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (burst_cnt == CNT_MAX && req0) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                        cont = 1'b1;
                    end
                end else begin
                    gnt0 = idle_g0;
                    gnt1 = idle_g1;
                end
            end
            default: begin
                gnt0 = idle_g0;
                gnt1 = idle_g1;
            end
        endcase
        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // A continuing owner counts up and saturates; a fresh lock starts at one.
    always_comb begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
        last_gnt_nxt  = last_gnt;
        if (gnt0) begin
            last_gnt_nxt = 1'b0;
            if (lock0) begin
                state_nxt     = OWN0;
                burst_cnt_nxt = !cont ? CNT_ONE :
                                (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;
            end
        end else if (gnt1) begin
            last_gnt_nxt = 1'b1;
            if (lock1) begin
                state_nxt     = OWN1;
                burst_cnt_nxt = !cont ? CNT_ONE :
                                (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            rvalid0   <= gnt0 & ~we0;
            rvalid1   <= gnt1 & ~we1;
        end
    end

    // Address is held across idle cycles so the memory pins do not toggle.
    always_ff @(posedge CLK) begin
        if (gnt0 | gnt1) begin
            addr_hold <= mem_addr;
        end
    end

    assign mem_addr  = gnt0 ? addr0 : (gnt1 ? addr1 : addr_hold);
    assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 256x8 synchronous memory plus per-port
// queues of expected read data, popped when rvalid appears.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MAX_BURST = 4;

    logic          CLK = 1'b0;
    logic          reset_n;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [256];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        mem_rdata <= mem[mem_addr];
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step;
        pre_we = 1'b0;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        req0 = 0; we0 = 0; lock0 = 0; req1 = 0; we1 = 0; lock1 = 0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        step;
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt_we: got %b want 000", {gnt0, gnt1, mem_we});
        end
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1});
        end
        step;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        reset_n = 1'b1;
        step;
    endtask

    task automatic test_single_read;
        logic [DW-1:0] exp;
        preload(8'd1, 8'h03);
        preload(8'd2, 8'h5a);
        req0 = 1; we0 = 0; addr0 = 8'd1;
        q0.push_back(8'h03);
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1} !== 2'b10 || mem_addr !== 8'd1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b addr=%h we=%b want gnt=10 addr=01 we=0",
                     {gnt0, gnt1}, mem_addr, mem_we);
        end
        step;
        req0 = 0;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || q0.size() == 0) begin
            errors++;
            $display("FAIL single_rvalid: got %b want 1", rvalid0);
        end else begin
            exp = q0.pop_front();
            if (rdata0 !== exp) begin
                errors++;
                $display("FAIL single_rdata: got %h want %h", rdata0, exp);
            end
        end
        checks++;
        if ({gnt0, gnt1, rvalid1} !== 3'b000) begin
            errors++;
            $display("FAIL single_quiet: got %b want 000", {gnt0, gnt1, rvalid1});
        end
        step;
    endtask

    task automatic test_tie;
        logic          e0, pe0;
        logic [DW-1:0] exp;
        apply_reset;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'd1; addr1 = 8'd2;
        pe0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin req0 = 0; req1 = 0; end
            @(negedge CLK);
            e0 = (i % 2 == 0);
            if (i < 6) begin
                checks++;
                if (gnt0 !== e0 || gnt1 !== !e0) begin
                    errors++;
                    $display("FAIL tie_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {e0, !e0});
                end
                if (e0) q0.push_back(8'h03);
                else    q1.push_back(8'h5a);
            end
            if (i > 0) begin
                checks++;
                if (rvalid0 !== pe0 || rvalid1 !== !pe0) begin
                    errors++;
                    $display("FAIL tie_rvalid[%0d]: got %b want %b", i, {rvalid0, rvalid1}, {pe0, !pe0});
                end else if (rvalid0 && q0.size() != 0) begin
                    exp = q0.pop_front();
                    if (rdata0 !== exp) begin
                        errors++;
                        $display("FAIL tie_rdata0[%0d]: got %h want %h", i, rdata0, exp);
                    end
                end else if (rvalid1 && q1.size() != 0) begin
                    exp = q1.pop_front();
                    if (rdata1 !== exp) begin
                        errors++;
                        $display("FAIL tie_rdata1[%0d]: got %h want %h", i, rdata1, exp);
                    end
                end
            end
            pe0 = e0;
            step;
        end
    endtask

    task automatic test_locked_burst;
        logic [DW-1:0] bdata [4];
        logic [DW-1:0] exp;
        bdata = '{8'h03, 8'hff, 8'hff, 8'hfb};
        req1 = 1; we1 = 1;
        for (int i = 0; i < 4; i++) begin
            addr1 = AW'(i + 1); wdata1 = bdata[i]; lock1 = (i < 3);
            @(negedge CLK);
            checks++;
            if ({gnt0, gnt1, mem_we} !== 3'b011 || mem_addr !== AW'(i + 1) || mem_wdata !== bdata[i]) begin
                errors++;
                $display("FAIL burst_write[%0d]: got gnt=%b we=%b addr=%h data=%h want gnt=01 we=1 addr=%h data=%h",
                         i, {gnt0, gnt1}, mem_we, mem_addr, mem_wdata, AW'(i + 1), bdata[i]);
            end
            step;
        end
        req1 = 0; we1 = 0; lock1 = 0;
        for (int i = 0; i < 5; i++) begin
            req0 = (i < 4); we0 = 0; addr0 = AW'(i + 1);
            if (i < 4) q0.push_back(bdata[i]);
            @(negedge CLK);
            if (i < 4) begin
                checks++;
                if ({gnt0, gnt1} !== 2'b10) begin
                    errors++;
                    $display("FAIL burst_readback_gnt[%0d]: got %b want 10", i, {gnt0, gnt1});
                end
            end
            if (i > 0) begin
                checks++;
                if (rvalid0 !== 1'b1 || q0.size() == 0) begin
                    errors++;
                    $display("FAIL burst_readback_rvalid[%0d]: got %b want 1", i, rvalid0);
                end else begin
                    exp = q0.pop_front();
                    if (rdata0 !== exp) begin
                        errors++;
                        $display("FAIL burst_readback_data[%0d]: got %h want %h", i, rdata0, exp);
                    end
                end
            end
            step;
        end
    endtask

    task automatic test_forced_release;
        logic          eg1, peg1;
        logic          egv [8];
        logic [DW-1:0] exp;
        egv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        req1 = 1; lock1 = 1; we1 = 0; addr1 = 8'd2;
        we0 = 0; lock0 = 0; addr0 = 8'd4;
        peg1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req0 = (i >= 2 && i <= 4);
            if (i == 8) begin req1 = 0; lock1 = 0; end
            @(negedge CLK);
            if (i < 8) begin
                eg1 = egv[i];
                checks++;
                if (gnt1 !== eg1 || gnt0 !== !eg1) begin
                    errors++;
                    $display("FAIL forced_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {!eg1, eg1});
                end
                if (eg1) q1.push_back(8'hff);
                else     q0.push_back(8'hfb);
            end
            if (i > 0) begin
                checks++;
                if (rvalid1 !== peg1 || rvalid0 !== !peg1) begin
                    errors++;
                    $display("FAIL forced_rvalid[%0d]: got %b want %b", i, {rvalid0, rvalid1}, {!peg1, peg1});
                end else if (rvalid1 && q1.size() != 0) begin
                    exp = q1.pop_front();
                    if (rdata1 !== exp) begin
                        errors++;
                        $display("FAIL forced_rdata1[%0d]: got %h want %h", i, rdata1, exp);
                    end
                end else if (rvalid0 && q0.size() != 0) begin
                    exp = q0.pop_front();
                    if (rdata0 !== exp) begin
                        errors++;
                        $display("FAIL forced_rdata0[%0d]: got %h want %h", i, rdata0, exp);
                    end
                end
            end
            if (i < 8) peg1 = egv[i];
            step;
        end
    endtask

    task automatic test_reset_mid_read;
        logic [DW-1:0] exp;
        req0 = 1; we0 = 0; addr0 = 8'd1; req1 = 0; lock0 = 0; lock1 = 0;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_gnt: got %b want 1", gnt0);
        end
        #1;
        reset_n = 1'b0;
        req0 = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_during: got %b want 000", {gnt0, gnt1, rvalid0});
        end
        #1;
        reset_n = 1'b1;
        step;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin
                errors++;
                $display("FAIL midreset_after[%0d]: got %b want 0000", k, {gnt0, gnt1, rvalid0, rvalid1});
            end
            step;
        end
        req0 = 1; req1 = 1; addr0 = 8'd1; addr1 = 8'd2;
        q0.push_back(8'h03);
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_tie: got %b want 10", {gnt0, gnt1});
        end
        step;
        req0 = 0; req1 = 0;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || q0.size() == 0) begin
            errors++;
            $display("FAIL midreset_tie_rvalid: got %b want 1", rvalid0);
        end else begin
            exp = q0.pop_front();
            if (rdata0 !== exp) begin
                errors++;
                $display("FAIL midreset_tie_rdata: got %h want %h", rdata0, exp);
            end
        end
        step;
    endtask

    task automatic test_write_no_readback;
        logic [DW-1:0] exp;
        req0 = 1; we0 = 1; addr0 = 8'd5; wdata0 = 8'h12;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd5 || mem_wdata !== 8'h12) begin
            errors++;
            $display("FAIL write_strobe: got gnt0=%b we=%b addr=%h data=%h want 1 1 05 12",
                     gnt0, mem_we, mem_addr, mem_wdata);
        end
        step;
        req0 = 0; we0 = 0;
        @(negedge CLK);
        checks++;
        if (mem_we !== 1'b0 || rvalid0 !== 1'b0 || mem_addr !== 8'd5) begin
            errors++;
            $display("FAIL write_after: got we=%b rvalid0=%b addr=%h want 0 0 05", mem_we, rvalid0, mem_addr);
        end
        step;
        req1 = 1; we1 = 0; addr1 = 8'd5;
        q1.push_back(8'h12);
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1} !== 2'b01 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL write_loader_gnt: got gnt=%b rvalid0=%b want 01 0", {gnt0, gnt1}, rvalid0);
        end
        step;
        req1 = 0;
        @(negedge CLK);
        checks++;
        if (rvalid1 !== 1'b1 || q1.size() == 0) begin
            errors++;
            $display("FAIL write_readback_rvalid: got %b want 1", rvalid1);
        end else begin
            exp = q1.pop_front();
            if (rdata1 !== exp) begin
                errors++;
                $display("FAIL write_readback_rdata: got %h want %h", rdata1, exp);
            end
        end
        step;
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        step;
        test_reset;
        test_single_read;
        test_tie;
        test_locked_burst;
        test_forced_release;
        test_reset_mid_read;
        test_write_no_readback;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port 256x8 data memory between the core load/store path (requester 0) and the loader/debug port (requester 1). The loader port preloads operands and reads results while the core runs. The block sits between both requesters and the data memory instance inside TopLevel. It provides round-robin fairness, locked bursts for multi-byte operands, and a bounded lock hold so neither side starves.

Parameters:
AW, 8, address width (256-byte data memory)
DW, 8, data width
MAX_BURST, 4, maximum consecutive granted cycles under lock while the other side is requesting

Ports:
CLK  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  core access request
we0  input  1  core write enable (1 = write, 0 = read)
addr0  input  AW  core address
wdata0  input  DW  core write data
lock0  input  1  core requests that the grant be held next cycle
gnt0  output  1  core access performed this cycle
rvalid0  output  1  core read data valid
rdata0  output  DW  core read data
req1, we1, addr1, wdata1, lock1  input  1/1/AW/DW/1  loader port, same meaning as the core port
gnt1, rvalid1, rdata1  output  1/1/DW  loader port, same meaning as the core port
mem_addr  output  AW  data memory address
mem_we  output  1  data memory write strobe
mem_wdata  output  DW  data memory write data
mem_rdata  input  DW  data memory read data, synchronous, 1-cycle latency

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, last_gnt=1 (so the core wins the first tie), burst_cnt=0, rvalid0=rvalid1=0. Combinational outputs: gnt0=gnt1=0 and mem_we=0 while in reset. mem_addr and mem_wdata are don't-care.
- Grants are combinational from (req, state, last_gnt, burst_cnt). The access occurs in the cycle gnt is high: mem_addr, mem_we and mem_wdata are muxed from the granted port. At most one gnt is high per cycle. A gnt is never asserted without the matching req.
- No grant: mem_we=0 and mem_addr holds its previous value (registered hold, no glitching toggles).
- Read latency: rvalid(n) is asserted exactly one cycle after a read grant to port n. rdata(n)=mem_rdata in that cycle. rdata is undefined when rvalid is low. A write grant never produces rvalid.
- State machine:
  - IDLE, one req: grant it.
  - IDLE, both req: grant the port that is not last_gnt.
  - IDLE, granted with lock set: go to OWNn with burst_cnt=1. Granted without lock: stay in IDLE. In both cases last_gnt=n.
  - OWNn, req(n)=1: grant n and increment burst_cnt.
  - OWNn, lock(n)=0 on a granted cycle: go to IDLE after that cycle.
  - OWNn, req(n)=0: release immediately. Go to IDLE behaviour in the same cycle, so the other port may be granted that cycle.
  - Forced release: in OWNn, if burst_cnt==MAX_BURST and req(other)=1, then gnt(n)=0, the other port is granted, and the state goes to IDLE, or to OWN(other) if lock(other)=1. If the other port is not requesting, the owner keeps the grant. burst_cnt saturates at MAX_BURST.
- Simultaneous events:
  - Lock deasserted in the same cycle as a forced release: release takes priority and the owner is not granted.
  - Same-address write by one port and read by the other: impossible, since only one port is granted.
- Reset mid-burst: state returns to IDLE and any pending rvalid is dropped (not delivered after reset release).
- No combinational path from mem_rdata to any gnt.

Test Plan:
- Single core read: preload mem[1]=8'h03. Core: req0=1, we0=0, addr0=1 for one cycle -> gnt0=1 that cycle; next cycle rvalid0=1, rdata0=8'h03; gnt1 and rvalid1 stay 0.
- Tie after reset: req0=req1=1 continuously, no lock -> grants alternate gnt0, gnt1, gnt0, gnt1, with core first.
- Locked burst: loader writes 8'h03, 8'hff, 8'hff, 8'hfb to addresses 1-4 with lock1=1 on the first three writes, core idle -> four consecutive gnt1. mem[1..4]=03 ff ff fb. State is IDLE afterwards.
- Forced release (MAX_BURST=4): loader holds lock1=1 and req1=1 indefinitely. Core raises req0 at cycle 2 -> gnt1 in cycles 0-3, gnt0 in cycle 4 (not earlier), then gnt1 resumes.
- Reset mid-read: core read granted, reset_n pulsed low before the next rising edge -> rvalid0 never asserts. After release, gnt0=gnt1=0 until a new req, and the first tie goes to the core.
- Write with no read-back: core writes addr 5 = 8'h12 -> mem_we=1 for exactly one cycle with mem_addr=5 and mem_wdata=8'h12. No rvalid follows. A loader read of address 5 two cycles later returns 8'h12.
